// File: rtl/regfile_wb_queue.sv
// Register-file writeback arbiter.
// Port A writes ALU results one cycle after the request and has no
// backpressure. Port B drains a small in-order queue of LSU load results.
// An ALU write to a register kills any older queued LSU write to that same
// register, because the ALU result is younger. chk_hit_o reports whether a
// register still has a live queued write.
//
// Ports:
//   clk, rst                              clock; asynchronous active-high reset
//   alu_valid_i/alu_addr_i/alu_data_i     ALU writeback request
//   lsu_valid_i/lsu_addr_i/lsu_data_i     LSU writeback request
//   lsu_ready_o                           queue has room; depends on state only
//   hold_i                                stalls draining of the queue
//   chk_addr_i/chk_hit_o                  hazard query against live entries
//   we_a_o/waddr_a_o/wdata_a_o            register-file write port A (ALU)
//   we_b_o/waddr_b_o/wdata_b_o            register-file write port B (LSU)
//   count_o                               occupied entries, live or dead
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid_i,
  input  logic [4:0]               alu_addr_i,
  input  logic [31:0]              alu_data_i,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [4:0]               lsu_addr_i,
  input  logic [31:0]              lsu_data_i,
  input  logic                     hold_i,
  input  logic [4:0]               chk_addr_i,
  output logic                     chk_hit_o,
  output logic                     we_a_o,
  output logic [4:0]               waddr_a_o,
  output logic [31:0]              wdata_a_o,
  output logic                     we_b_o,
  output logic [4:0]               waddr_b_o,
  output logic [31:0]              wdata_b_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [DEPTH-1:0] live_d;
  logic [DEPTH-1:0] kill_vec;
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [AW:0]      count_q;

  logic alu_wr;
  logic push_st;
  logic pop;
  logic head_live;
  logic hit;

  assign alu_wr      = alu_valid_i && (alu_addr_i != '0);
  assign lsu_ready_o = (count_q < FULL);
  // An address-0 request still completes its handshake but stores nothing.
  assign push_st     = lsu_valid_i && lsu_ready_o && (lsu_addr_i != '0);
  assign pop         = !hold_i && (count_q != '0);
  assign count_o     = count_q;

  // Kills apply only to entries already stored, never to this cycle's push.
  always_comb begin
    kill_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kill_vec[i] = alu_wr && live_q[i] && (q_addr[i] == alu_addr_i);
    end
  end

  // The head being popped is also subject to this cycle's kill.
  assign head_live = live_q[head_q] && !kill_vec[head_q];

  // Kill first, then retire the head, then mark the new tail live. Push and
  // pop never share a slot: head==tail only when empty or full.
  always_comb begin
    live_d = live_q & ~kill_vec;
    if (pop)     live_d[head_q] = 1'b0;
    if (push_st) live_d[tail_q] = 1'b1;
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (q_addr[i] == chk_addr_i)) hit = 1'b1;
    end
    chk_hit_o = hit && (chk_addr_i != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      we_b_o    <= 1'b0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      live_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      we_a_o <= alu_wr;
      if (alu_wr) begin
        waddr_a_o <= alu_addr_i;
        wdata_a_o <= alu_data_i;
      end

      if (pop) begin
        we_b_o <= head_live;
        if (head_live) begin
          waddr_b_o <= q_addr[head_q];
          wdata_b_o <= q_data[head_q];
        end
        head_q <= head_q + AW'(1);
      end else begin
        we_b_o <= 1'b0;
      end

      if (push_st) begin
        q_addr[tail_q] <= lsu_addr_i;
        q_data[tail_q] <= lsu_data_i;
        tail_q         <= tail_q + AW'(1);
      end

      live_q <= live_d;

      case ({push_st, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        alu_valid_i;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic        hold_i;
  logic [4:0]  chk_addr_i;
  logic        chk_hit_o;
  logic        we_a_o;
  logic [4:0]  waddr_a_o;
  logic [31:0] wdata_a_o;
  logic        we_b_o;
  logic [4:0]  waddr_b_o;
  logic [31:0] wdata_b_o;
  logic [2:0]  count_o;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .hold_i(hold_i), .chk_addr_i(chk_addr_i), .chk_hit_o(chk_hit_o),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an in-order list of pending LSU writes, each live or dead.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } ent_t;
  ent_t mq[$];

  logic        e_we_a, e_we_b;
  logic [4:0]  e_waddr_a, e_waddr_b;
  logic [31:0] e_wdata_a, e_wdata_b;

  logic        obs_ready, obs_hit, exp_ready, exp_hit;
  int          obs_count, exp_count;

  function automatic void model_reset();
    mq.delete();
    e_we_a = 0; e_waddr_a = '0; e_wdata_a = '0;
    e_we_b = 0; e_waddr_b = '0; e_wdata_b = '0;
  endfunction

  function automatic bit model_hit(logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step();
    bit   room;
    bit   akill;
    ent_t e;
    room  = (mq.size() < DEPTH);
    akill = alu_valid_i && (alu_addr_i != 5'd0);
    if (akill) foreach (mq[i]) if (mq[i].addr == alu_addr_i) mq[i].live = 1'b0;
    e_we_b = 1'b0;
    if (!hold_i && mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live) begin
        e_we_b = 1'b1; e_waddr_b = e.addr; e_wdata_b = e.data;
      end
    end
    if (lsu_valid_i && room && lsu_addr_i != 5'd0)
      mq.push_back('{addr: lsu_addr_i, data: lsu_data_i, live: 1'b1});
    e_we_a = akill;
    if (akill) begin
      e_waddr_a = alu_addr_i; e_wdata_a = alu_data_i;
    end
  endfunction

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic h, input logic [4:0] ca);
    alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
    lsu_valid_i = lv; lsu_addr_i = la; lsu_data_i = ld;
    hold_i = h; chk_addr_i = ca;
  endtask

  // Called at edge+1: samples combinational outputs, advances one clock and
  // the model, and returns at the next edge+1.
  task automatic tick();
    #1;
    obs_ready = lsu_ready_o; obs_hit = chk_hit_o; obs_count = int'(count_o);
    exp_ready = (mq.size() < DEPTH);
    exp_hit   = model_hit(chk_addr_i);
    exp_count = mq.size();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd5);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (we_a_o !== 1'b0 || waddr_a_o !== 5'd0 || wdata_a_o !== 32'd0) begin
      errors++; $display("FAIL reset_port_a: got we=%0b a=%0d d=%0h want 0/0/0", we_a_o, waddr_a_o, wdata_a_o); end
    checks++; if (we_b_o !== 1'b0 || waddr_b_o !== 5'd0 || wdata_b_o !== 32'd0) begin
      errors++; $display("FAIL reset_port_b: got we=%0b a=%0d d=%0h want 0/0/0", we_b_o, waddr_b_o, wdata_b_o); end
    checks++; if (count_o !== 3'd0 || lsu_ready_o !== 1'b1 || chk_hit_o !== 1'b0) begin
      errors++; $display("FAIL reset_status: got cnt=%0d rdy=%0b hit=%0b want 0/1/0", count_o, lsu_ready_o, chk_hit_o); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_alu();
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 0, 5'd0);
    tick();
    checks++; if (we_a_o !== 1'b1 || waddr_a_o !== 5'd5 || wdata_a_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_x5: got we=%0b a=%0d d=%0h want 1/5/deadbeef", we_a_o, waddr_a_o, wdata_a_o); end
    drive(1, 5'd0, 32'h12345678, 0, 5'd0, 0, 0, 5'd0);
    tick();
    checks++; if (we_a_o !== 1'b0 || waddr_a_o !== 5'd5 || wdata_a_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_x0: got we=%0b a=%0d d=%0h want 0/5/deadbeef", we_a_o, waddr_a_o, wdata_a_o); end
    drive(0, 5'd3, 32'h1, 0, 5'd0, 0, 0, 5'd0);
    tick();
    checks++; if (we_a_o !== 1'b0) begin
      errors++; $display("FAIL alu_idle: got we=%0b want 0", we_a_o); end
  endtask

  task automatic test_hold_fill();
    logic [31:0] d [5];
    for (int i = 1; i <= 4; i++) begin
      d[i] = $urandom;
      drive(0, 5'd0, 0, 1, 5'(i), d[i], 1, 5'd0);
      tick();
    end
    drive(0, 5'd0, 0, 1, 5'd5, 32'hBAD, 1, 5'd0);
    tick();
    checks++; if (obs_count != 4 || obs_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got cnt=%0d rdy=%0b want 4/0", obs_count, obs_ready); end
    checks++; if (count_o !== 3'd4) begin
      errors++; $display("FAIL fill_reject: got cnt=%0d want 4", count_o); end
    drive(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'(i) || wdata_b_o !== d[i]) begin
        errors++; $display("FAIL drain_%0d: got we=%0b a=%0d d=%0h want 1/%0d/%0h", i, we_b_o, waddr_b_o, wdata_b_o, i, d[i]); end
    end
    checks++; if (count_o !== 3'd0) begin
      errors++; $display("FAIL drain_count: got %0d want 0", count_o); end
    tick();
    checks++; if (we_b_o !== 1'b0) begin
      errors++; $display("FAIL drain_idle: got we_b=%0b want 0", we_b_o); end
  endtask

  task automatic test_kill();
    drive(0, 5'd0, 0, 1, 5'd7, 32'h11, 1, 5'd7);
    tick();
    drive(1, 5'd7, 32'h22, 0, 5'd0, 0, 1, 5'd7);
    tick();
    drive(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd7);
    #1;
    checks++; if (chk_hit_o !== 1'b0 || count_o !== 3'd1) begin
      errors++; $display("FAIL kill_hit: got hit=%0b cnt=%0d want 0/1", chk_hit_o, count_o); end
    hold_i = 1'b0;
    #0;
    tick();
    checks++; if (we_b_o !== 1'b0 || waddr_a_o !== 5'd7 || wdata_a_o !== 32'h22) begin
      errors++; $display("FAIL kill_pop: got we_b=%0b a_a=%0d d_a=%0h want 0/7/22", we_b_o, waddr_a_o, wdata_a_o); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    d = $urandom;
    drive(1, 5'd9, 32'hA5A5, 1, 5'd9, d, 1, 5'd9);
    tick();
    drive(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd9);
    #1;
    checks++; if (chk_hit_o !== 1'b1) begin
      errors++; $display("FAIL same_hit: got %0b want 1", chk_hit_o); end
    hold_i = 1'b0;
    tick();
    checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd9 || wdata_b_o !== d) begin
      errors++; $display("FAIL same_pop: got we=%0b a=%0d d=%0h want 1/9/%0h", we_b_o, waddr_b_o, wdata_b_o, d); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'd0, 0, 1, 5'(10 + i), $urandom, 1, 5'd0);
      tick();
    end
    drive(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd0);
    #1;
    checks++; if (count_o !== 3'd3) begin
      errors++; $display("FAIL mid_count: got %0d want 3", count_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (count_o !== 3'd0 || we_b_o !== 1'b0 || lsu_ready_o !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got cnt=%0d we_b=%0b rdy=%0b want 0/0/1", count_o, we_b_o, lsu_ready_o); end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 5'd0, 0, 1, 5'd3, 32'h3333, 0, 5'd0);
    tick();
    drive(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    tick();
    checks++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd3 || wdata_b_o !== 32'h3333) begin
      errors++; $display("FAIL mid_push: got we=%0b a=%0d d=%0h want 1/3/3333", we_b_o, waddr_b_o, wdata_b_o); end
    tick();
    checks++; if (we_b_o !== 1'b0 || count_o !== 3'd0) begin
      errors++; $display("FAIL mid_sole: got we=%0b cnt=%0d want 0/0", we_b_o, count_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] d [12];
    for (int i = 0; i < 12; i++) d[i] = $urandom;
    for (int i = 0; i < 2; i++) begin
      drive(0, 5'd0, 0, 1, 5'(16 + i), d[i], 1, 5'd0);
      tick();
    end
    for (int i = 2; i < 12; i++) begin
      drive(0, 5'd0, 0, 1, 5'(16 + i), d[i], 0, 5'd0);
      tick();
      checks++; if (count_o !== 3'd2 || we_b_o !== 1'b1 || waddr_b_o !== 5'(14 + i) || wdata_b_o !== d[i-2]) begin
        errors++; $display("FAIL wrap_%0d: got cnt=%0d we=%0b a=%0d d=%0h want 2/1/%0d/%0h",
                           i, count_o, we_b_o, waddr_b_o, wdata_b_o, 14 + i, d[i-2]); end
    end
    drive(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    tick(); tick();
    checks++; if (count_o !== 3'd0 || waddr_b_o !== 5'd27 || wdata_b_o !== d[11]) begin
      errors++; $display("FAIL wrap_end: got cnt=%0d a=%0d want 0/27", count_o, waddr_b_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 99) < 35), 5'($urandom_range(0, 7)));
      tick();
      checks++; if (obs_ready !== exp_ready || obs_hit !== exp_hit || obs_count != exp_count) begin
        errors++; $display("FAIL rnd_comb@%0d: got rdy=%0b hit=%0b cnt=%0d want %0b/%0b/%0d",
                           n, obs_ready, obs_hit, obs_count, exp_ready, exp_hit, exp_count); end
      checks++; if (we_a_o !== e_we_a || waddr_a_o !== e_waddr_a || wdata_a_o !== e_wdata_a) begin
        errors++; $display("FAIL rnd_a@%0d: got %0b/%0d/%0h want %0b/%0d/%0h",
                           n, we_a_o, waddr_a_o, wdata_a_o, e_we_a, e_waddr_a, e_wdata_a); end
      checks++; if (we_b_o !== e_we_b || waddr_b_o !== e_waddr_b || wdata_b_o !== e_wdata_b) begin
        errors++; $display("FAIL rnd_b@%0d: got %0b/%0d/%0h want %0b/%0d/%0h",
                           n, we_b_o, waddr_b_o, wdata_b_o, e_we_b, e_waddr_b, e_wdata_b); end
      checks++; if ((we_a_o && waddr_a_o == 5'd0) || (we_b_o && waddr_b_o == 5'd0)) begin
        errors++; $display("FAIL rnd_x0@%0d: got write to x0 (we_a=%0b we_b=%0b) want none", n, we_a_o, we_b_o); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_hold_fill();
    test_kill();
    test_same_cycle();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, LSU-result queue entries; power of 2, >= 2.
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port alu_valid_i  in  1  ALU writeback request this cycle; no backpressure.
REQ-005 SHALL have port alu_addr_i  in  5  ALU destination register.
REQ-006 SHALL have port alu_data_i  in  32  ALU result.
REQ-007 SHALL have port lsu_valid_i  in  1  LSU writeback request.
REQ-008 SHALL have port lsu_ready_o  out  1  queue can accept an LSU request.
REQ-009 SHALL have port lsu_addr_i  in  5  LSU destination register.
REQ-010 SHALL have port lsu_data_i  in  32  LSU load data.
REQ-011 SHALL have port hold_i  in  1  blocks queue drain this cycle.
REQ-012 SHALL have port chk_addr_i  in  5  hazard-query register address.
REQ-013 SHALL have port chk_hit_o  out  1  query address has a live queued write.
REQ-014 SHALL have port we_a_o / waddr_a_o / wdata_a_o  out  1/5/32  register-file write port A (ALU).
REQ-015 SHALL have port we_b_o / waddr_b_o / wdata_b_o  out  1/5/32  register-file write port B (LSU).
REQ-016 SHALL have port count_o  out  clog2(DEPTH)+1  occupied entries, live or dead.

Function
REQ-017 SHALL register port A: each edge, we_a_o <= alu_valid_i && alu_addr_i != 0; waddr_a_o/wdata_a_o load on that condition, else hold; latency 1 cycle.
REQ-018 SHALL drive lsu_ready_o = (count_o < DEPTH), combinational from state only; no same-cycle pop credit.
REQ-019 SHALL push when lsu_valid_i && lsu_ready_o: nonzero addr -> entry stored live at tail; addr 0 -> handshake completes, nothing stored, count unchanged.
REQ-020 SHALL pop head when !hold_i && count_o > 0: head live -> we_b_o <= 1, waddr_b_o/wdata_b_o <= head; head dead -> we_b_o <= 0; otherwise we_b_o <= 0, addr/data hold.
REQ-021 SHALL on push and pop in the same cycle keep count_o unchanged; head/tail pointers wrap modulo DEPTH.
REQ-022 SHALL on alu_valid_i with nonzero alu_addr_i mark dead every already-stored live entry whose addr matches, including the head being popped that cycle (ALU result younger).
REQ-023 SHALL NOT kill an entry pushed in the same cycle as a matching ALU request (LSU push is younger); it stays live.
REQ-024 SHALL drive chk_hit_o = 1 iff chk_addr_i != 0 and any live stored entry matches; combinational, excludes same-cycle push and the registered port-B output.
REQ-025 SHALL never assert we_a_o or we_b_o for address 0.
REQ-026 SHALL let hold_i affect only draining; pushes and kills proceed while held.

Reset
REQ-027 SHALL on rst assertion, asynchronously: we_a_o=0, we_b_o=0, waddr_*=0, wdata_*=0, count_o=0, pointers=0, all entries dead; chk_hit_o=0; lsu_ready_o=1.
REQ-028 SHALL discard queued entries on reset mid-operation; first push after deassertion lands at entry 0.

Verification
REQ-029 SHALL cover: ALU x5=0xDEADBEEF -> next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF; ALU x0 -> we_a_o=0.
REQ-030 SHALL cover: hold_i=1, push 4 LSU writes x1..x4 -> count_o=4, lsu_ready_o=0; release -> we_b_o for x1,x2,x3,x4 on 4 consecutive cycles, count_o back to 0.
REQ-031 SHALL cover: hold_i=1, queue x7=0x11 then ALU x7=0x22 -> chk_hit_o(7)=0; release -> we_b_o=0 on the pop, port A shows x7=0x22.
REQ-032 SHALL cover: same-cycle LSU push x9 and ALU x9 -> entry live, chk_hit_o(9)=1, later we_b_o=1 waddr_b_o=9.
REQ-033 SHALL cover: count_o=3 held, assert rst one cycle -> count_o=0, we_b_o=0, lsu_ready_o=1; next push x3 drains as sole write.
REQ-034 SHALL cover: push and pop same cycle at count_o=2 through wrap -> count_o stays 2, FIFO order preserved across wrap.
